// File: rtl/reg_dump_sequencer.sv
// Walks the core's register file after done, showing each 32-bit value on 16 LEDs
// as low half then high half. Optional build macro SKIP_ZERO_EN skips all-zero registers.
module reg_dump_sequencer #(
    parameter int DWELL    = 4,
    parameter int LAST_REG = 31,
    parameter int WRAP     = 1
) (
    input  logic        reset,
    input  logic        div_clk,
    input  logic        done,
    input  logic        pause,
    input  logic [31:0] reg_data,
    output logic [4:0]  reg_addr,
    output logic [15:0] led,
    output logic        show_hi,
    output logic        busy,
    output logic        dump_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SHOW_LO = 3'd2;
    localparam logic [2:0] S_SHOW_HI = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    localparam int          CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [4:0]  LAST_A   = 5'(LAST_REG);

    logic [2:0]    state_q, state_d;
    logic [4:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_m_q, done_s_q, pause_m_q, pause_s_q;

    // Where the walk goes after a register is finished (shown or skipped).
    logic [2:0] adv_state;
    logic [4:0] adv_addr;

    always_comb begin
        adv_state = S_LOAD;
        adv_addr  = addr_q + 5'd1;
        if (addr_q == LAST_A) begin
            if (WRAP != 0) begin
                adv_addr = 5'd0;
            end else begin
                adv_addr  = addr_q;
                adv_state = S_FINISH;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        // Losing done aborts ahead of pause and dwell expiry.
        if (state_q != S_IDLE && !done_s_q) begin
            state_d = S_IDLE;
            addr_d  = 5'd0;
            cnt_d   = '0;
            data_d  = 32'd0;
        end else if (pause_s_q && (state_q == S_LOAD || state_q == S_SHOW_LO ||
                                   state_q == S_SHOW_HI)) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (done_s_q) state_d = S_LOAD;
                end
                S_LOAD: begin
                    data_d  = reg_data;
                    cnt_d   = '0;
                    state_d = S_SHOW_LO;
`ifdef SKIP_ZERO_EN
                    if (reg_data == 32'd0) begin
                        state_d = adv_state;
                        addr_d  = adv_addr;
                    end
`endif
                end
                S_SHOW_LO: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_SHOW_HI;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_SHOW_HI: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = adv_state;
                        addr_d  = adv_addr;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_FINISH: state_d = S_FINISH;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge div_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 5'd0;
            data_q    <= 32'd0;
            cnt_q     <= '0;
            done_m_q  <= 1'b0;
            done_s_q  <= 1'b0;
            pause_m_q <= 1'b0;
            pause_s_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            done_m_q  <= done;
            done_s_q  <= done_m_q;
            pause_m_q <= pause;
            pause_s_q <= pause_m_q;
        end
    end

    assign reg_addr = addr_q;

    // LOAD shows a blank display; only SHOW states and FINISH expose data_q.
    always_comb begin
        led       = 16'd0;
        show_hi   = 1'b0;
        busy      = 1'b0;
        dump_done = 1'b0;
        case (state_q)
            S_LOAD:    busy = 1'b1;
            S_SHOW_LO: begin
                led  = data_q[15:0];
                busy = 1'b1;
            end
            S_SHOW_HI: begin
                led     = data_q[31:16];
                show_hi = 1'b1;
                busy    = 1'b1;
            end
            S_FINISH: begin
                led       = data_q[31:16];
                show_hi   = 1'b1;
                dump_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Scoreboard bench for reg_dump_sequencer: three instances (long walk, stop at 3, wrap at 3).
module tb_reg_dump_sequencer;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] tag;
        logic [4:0]  addr;
        logic [15:0] led;
        logic        hi;
        logic        busy;
        logic        dd;
    } exp_t;

    logic        div_clk;
    logic        reset;
    logic        pause;
    logic        done_v  [3];
    logic [31:0] rd      [3];
    logic [4:0]  addr_o  [3];
    logic [15:0] led_o   [3];
    logic        hi_o    [3];
    logic        busy_o  [3];
    logic        dd_o    [3];

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   seq      = 0;

    function automatic logic [31:0] rmodel(input logic [4:0] a);
`ifdef SKIP_ZERO_EN
        if (a == 5'd2) return 32'd0;
`endif
        return 32'hA000_0000 + {27'd0, a};
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) rd[k] = rmodel(addr_o[k]);
    end

    reg_dump_sequencer #(.DWELL(2)) dut_a (
        .reset(reset), .div_clk(div_clk), .done(done_v[0]), .pause(pause),
        .reg_data(rd[0]), .reg_addr(addr_o[0]), .led(led_o[0]),
        .show_hi(hi_o[0]), .busy(busy_o[0]), .dump_done(dd_o[0]));

    reg_dump_sequencer #(.DWELL(2), .LAST_REG(3), .WRAP(0)) dut_b (
        .reset(reset), .div_clk(div_clk), .done(done_v[1]), .pause(pause),
        .reg_data(rd[1]), .reg_addr(addr_o[1]), .led(led_o[1]),
        .show_hi(hi_o[1]), .busy(busy_o[1]), .dump_done(dd_o[1]));

    reg_dump_sequencer #(.DWELL(2), .LAST_REG(3), .WRAP(1)) dut_c (
        .reset(reset), .div_clk(div_clk), .done(done_v[2]), .pause(pause),
        .reg_data(rd[2]), .reg_addr(addr_o[2]), .led(led_o[2]),
        .show_hi(hi_o[2]), .busy(busy_o[2]), .dump_done(dd_o[2]));

    initial div_clk = 1'b0;
    always #5 div_clk = ~div_clk;

    task automatic chk(input exp_t e);
        checks++;
        if ({addr_o[e.id], led_o[e.id], hi_o[e.id], busy_o[e.id], dd_o[e.id]} !==
            {e.addr, e.led, e.hi, e.busy, e.dd}) begin
            failures++;
            $display("FAIL sb%0d dut%0d: got addr=%0d led=%h hi=%b busy=%b dd=%b, want addr=%0d led=%h hi=%b busy=%b dd=%b",
                     e.tag, e.id, addr_o[e.id], led_o[e.id], hi_o[e.id], busy_o[e.id], dd_o[e.id],
                     e.addr, e.led, e.hi, e.busy, e.dd);
        end
    endtask

    // Monitor: compares one expected entry per falling edge.
    always @(negedge div_clk) begin
        if (sb.size() != 0) chk(sb.pop_front());
    end

    function automatic exp_t mk(input logic [1:0] id, input logic [4:0] a, input logic [15:0] l,
                                input logic h, input logic b, input logic d);
        exp_t e;
        e.id = id; e.tag = 16'(seq); e.addr = a; e.led = l; e.hi = h; e.busy = b; e.dd = d;
        seq++;
        return e;
    endfunction

    task automatic push(input logic [1:0] id, input logic [4:0] a, input logic [15:0] l,
                        input logic h, input logic b, input logic d);
        sb.push_back(mk(id, a, l, h, b, d));
    endtask

    task automatic tick();
        @(posedge div_clk);
        #1;
    endtask

    task automatic cyc(input logic [1:0] id, input logic [4:0] a, input logic [15:0] l,
                       input logic h, input logic b, input logic d);
        tick();
        push(id, a, l, h, b, d);
    endtask

    task automatic idle(input logic [1:0] id);
        cyc(id, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    // One register: LOAD tick, two low-half ticks, two high-half ticks.
    task automatic show_reg(input logic [1:0] id, input logic [4:0] a);
        logic [31:0] d;
        d = rmodel(a);
        cyc(id, a, 16'h0000, 1'b0, 1'b1, 1'b0);
        if (d != 32'd0) begin
            repeat (2) cyc(id, a, d[15:0], 1'b0, 1'b1, 1'b0);
            repeat (2) cyc(id, a, d[31:16], 1'b1, 1'b1, 1'b0);
        end
    endtask

    // Raise done after an edge: two more idle edges for the synchronizer, LOAD on the third.
    task automatic start(input logic [1:0] id);
        tick();
        done_v[id] = 1'b1;
        push(id, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        idle(id);
        idle(id);
    endtask

    initial begin
        reset = 1'b0;
        pause = 1'b0;
        for (int k = 0; k < 3; k++) done_v[k] = 1'b0;
        for (int k = 0; k < 3; k++) push(2'(k), 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        idle(0);
        idle(0);

        // Basic walk, then async reset in the high half of register 7.
        start(0);
        for (int r = 0; r < 7; r++) show_reg(0, 5'(r));
        cyc(0, 5'd7, 16'h0000, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc(0, 5'd7, 16'h0007, 1'b0, 1'b1, 1'b0);
        cyc(0, 5'd7, 16'hA000, 1'b1, 1'b1, 1'b0);
        @(negedge div_clk);
        #1;
        reset     = 1'b0;
        done_v[0] = 1'b0;
        #1;
        chk(mk(0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0));
        tick();
        reset = 1'b1;
        repeat (3) idle(0);

        // Pause lands in SHOW_LO cnt=0 of register 0 and holds it.
        tick();
        done_v[0] = 1'b1;
        push(0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        idle(0);
        tick();
        pause = 1'b1;
        push(0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(0, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 9) pause = 1'b0;
            push(0, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
        end
        repeat (2) cyc(0, 5'd0, 16'hA000, 1'b1, 1'b1, 1'b0);
        for (int r = 1; r < 5; r++) show_reg(0, 5'(r));

        // Abort lands on the same edge as the high-half dwell expiry of register 5.
        cyc(0, 5'd5, 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(0, 5'd5, 16'h0005, 1'b0, 1'b1, 1'b0);
        cyc(0, 5'd5, 16'h0005, 1'b0, 1'b1, 1'b0);
        done_v[0] = 1'b0;
        repeat (2) cyc(0, 5'd5, 16'hA000, 1'b1, 1'b1, 1'b0);
        repeat (2) idle(0);
        start(0);
        show_reg(0, 5'd0);
        done_v[0] = 1'b0;

        // LAST_REG=3, WRAP=0: stop in FINISH until done drops.
        start(1);
        for (int r = 0; r < 4; r++) show_reg(1, 5'(r));
        repeat (2) cyc(1, 5'd3, 16'hA000, 1'b1, 1'b0, 1'b1);
        tick();
        done_v[1] = 1'b0;
        push(1, 5'd3, 16'hA000, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc(1, 5'd3, 16'hA000, 1'b1, 1'b0, 1'b1);
        idle(1);

        // LAST_REG=3, WRAP=1: 3 -> 0 with busy held high.
        start(2);
        for (int r = 0; r < 4; r++) show_reg(2, 5'(r));
        cyc(2, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(2, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(2, 5'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
        cyc(2, 5'd0, 16'hA000, 1'b1, 1'b1, 1'b0);
        done_v[2] = 1'b0;

        @(negedge div_clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
